// File: rtl/booth4_seq_mult_ctrl_if.sv
// Operand/result handshake bundle for booth4_seq_mult_ctrl.
// master: operand source + result consumer side. slave: the multiplier.
interface booth4_seq_mult_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth4_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier, signed 16x16 -> 32.
// One Booth decoder and one 32-bit adder are reused over 8 steps; operands
// and result move over valid/ready handshakes.
// Optional feature macro: BOOTH4_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits can only produce zero partial products.
module booth4_seq_mult_ctrl #(
    parameter int NSTEP = 8,
    parameter int CNT_W = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    booth4_seq_mult_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [15:0]        r_a;
    logic [16:0]        r_inv_a;      // -A kept 17 bits wide so -(-32768) is exact
    logic [15:0]        r_b;
    logic [31:0]        r_acc;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [31:0]        r_product;
    logic               r_out_valid;

    logic [16:0]        w_b_ext;      // {B, 1'b0}: bit k holds B[k-1], so B[-1]=0
    logic [4:0]         w_shamt;      // 2*step
    logic [2:0]         w_code;
    logic [17:0]        w_pp;
    logic [31:0]        w_addend;
    logic [31:0]        w_acc_sum;
    logic               w_last;
    logic               w_early;
    logic               w_finish;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

    assign w_b_ext  = {r_b, 1'b0};
    assign w_shamt  = {1'b0, r_step_cnt, 1'b0};
    assign w_code   = w_b_ext[w_shamt +: 3];
    assign w_last   = (r_step_cnt == CNT_W'(NSTEP - 1));

    // Booth recoding of the current 3-bit window into an 18-bit signed partial product
    always_comb begin
        w_pp = '0;
        case (w_code)
            3'b001, 3'b010: w_pp = {{2{r_a[15]}}, r_a};
            3'b011:         w_pp = {r_a[15], r_a, 1'b0};
            3'b100:         w_pp = {r_inv_a, 1'b0};
            3'b101, 3'b110: w_pp = {r_inv_a[16], r_inv_a};
            default:        w_pp = '0;
        endcase
    end

    assign w_addend  = {{14{w_pp[17]}}, w_pp} << w_shamt;
    assign w_acc_sum = r_acc + w_addend;

`ifdef BOOTH4_EARLY_TERM_EN
    // Remaining window bits B[15:2i-1] all equal -> every later code is 000/111
    logic signed [16:0] w_b_rem;
    assign w_b_rem = $signed(w_b_ext) >>> w_shamt;
    assign w_early = (w_b_rem == '0) || (&w_b_rem);
`else
    assign w_early = 1'b0;
`endif

    assign w_finish = w_early || w_last;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, step until finished, hold until result taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_state_next = S_CALC;
            S_CALC: if (w_finish)     w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands, accumulate one Booth step per cycle, publish result
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_a         <= '0;
            r_inv_a     <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_step_cnt  <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.A;
                        r_inv_a    <= -{bus.A[15], bus.A};
                        r_b        <= bus.B;
                        r_acc      <= '0;
                        r_step_cnt <= '0;
                    end
                end
                S_CALC: begin
                    if (w_finish) begin
                        // On early exit this step's pp is zero, so skip the add
                        r_product   <= w_early ? r_acc : w_acc_sum;
                        r_acc       <= w_early ? r_acc : w_acc_sum;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_acc      <= w_acc_sum;
                        r_step_cnt <= r_step_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
// Directed + corner-weighted random bench for booth4_seq_mult_ctrl.
module tb_booth4_seq_mult_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    booth4_seq_mult_ctrl_if bus();

    booth4_seq_mult_ctrl dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

`ifdef BOOTH4_EARLY_TERM_EN
    localparam int LAT_3X5  = 3;
    localparam int LAT_NEG1 = 2;
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_3X5  = 8;
    localparam int LAT_NEG1 = 8;
    localparam int LAT_ZERO = 8;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and complete its handshake
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%0b required=1", bus.in_ready);
        end
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got in_ready=%0b out_valid=%0b busy=%0b required 1/0/0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.product !== 32'h0) begin
            failures++;
            $display("FAIL reset_product got=%h required=00000000", bus.product);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'd3, 16'd5);
        wait_valid(lat);
        checks++;
        if (lat !== LAT_3X5) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=%0d", lat, LAT_3X5);
        end
        checks++;
        if (bus.product !== 32'h0000_000F) begin
            failures++;
            $display("FAIL basic_3x5 got=%h required=0000000f", bus.product);
        end
        drain();
        $display("op 3*5 product=%h latency=%0d", bus.product, lat);
    endtask

    task automatic test_extremes();
        int lat;
        start_op(16'h8000, 16'h8000);
        wait_valid(lat);
        checks++;
        if (bus.product !== 32'h4000_0000) begin
            failures++;
            $display("FAIL min_x_min got=%h required=40000000", bus.product);
        end
        drain();
        $display("op 8000*8000 product=%h", bus.product);

        start_op(16'h8000, 16'h7FFF);
        wait_valid(lat);
        checks++;
        if (bus.product !== 32'hC000_8000) begin
            failures++;
            $display("FAIL min_x_max got=%h required=c0008000", bus.product);
        end
        drain();
        $display("op 8000*7fff product=%h", bus.product);

        start_op(16'd7, 16'hFFFF);
        wait_valid(lat);
        checks++;
        if (bus.product !== 32'hFFFF_FFF9 || lat !== LAT_NEG1) begin
            failures++;
            $display("FAIL seven_x_neg1 got=%h lat=%0d required=fffffff9 lat=%0d",
                     bus.product, lat, LAT_NEG1);
        end
        drain();
        $display("op 7*ffff product=%h latency=%0d", bus.product, lat);

        start_op(16'h1234, 16'h0000);
        wait_valid(lat);
        checks++;
        if (bus.product !== 32'h0 || lat !== LAT_ZERO) begin
            failures++;
            $display("FAIL b_zero got=%h lat=%0d required=00000000 lat=%0d",
                     bus.product, lat, LAT_ZERO);
        end
        drain();
        $display("op 1234*0 product=%h latency=%0d", bus.product, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        // -100 * 250 = -25000
        start_op(16'hFF9C, 16'd250);
        wait_valid(lat);
        bus.in_valid = 1'b1;
        bus.A = 16'd1;
        bus.B = 16'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.product !== 32'hFFFF_9E58 ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got valid=%0b prod=%h in_ready=%0b busy=%0b required 1/ffff9e58/0/1",
                         i, bus.out_valid, bus.product, bus.in_ready, bus.busy);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.product !== 32'hFFFF_9E58) begin
            failures++;
            $display("FAIL stall_release got valid=%0b in_ready=%0b busy=%0b prod=%h required 0/1/0/ffff9e58",
                     bus.out_valid, bus.in_ready, bus.busy, bus.product);
        end
        $display("op ff9c*00fa stalled 3 cycles product=%h", bus.product);
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        start_op(16'h1111, 16'h2222);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.product !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got valid=%0b busy=%0b in_ready=%0b prod=%h required 0/0/1/00000000",
                     bus.out_valid, bus.busy, bus.in_ready, bus.product);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_discard got out_valid=%0b required=0", bus.out_valid);
        end
        start_op(16'hFFFE, 16'hFFFD);
        wait_valid(lat);
        checks++;
        if (bus.product !== 32'd6) begin
            failures++;
            $display("FAIL after_reset_op got=%h required=00000006", bus.product);
        end
        drain();
        $display("op fffe*fffd after reset product=%h", bus.product);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] expv [2];
        logic [15:0] av [2];
        logic [15:0] bv [2];
        av[0] = 16'd1000;  bv[0] = 16'hFFF6;  expv[0] = 32'hFFFF_D8F0; // 1000*-10
        av[1] = 16'h7FFF;  bv[1] = 16'h7FFF;  expv[1] = 32'h3FFF_0001;
        bus.out_ready = 1'b1;   // ready before valid rises
        for (int k = 0; k < 2; k++) begin
            start_op(av[k], bv[k]);
            wait_valid(lat);
            checks++;
            if (bus.product !== expv[k] || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d got valid=%0b prod=%h required 1/%h",
                         k, bus.out_valid, bus.product, expv[k]);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_release_%0d got valid=%0b in_ready=%0b required 0/1",
                         k, bus.out_valid, bus.in_ready);
            end
            $display("op %h*%h zero-wait product=%h", av[k], bv[k], expv[k]);
        end
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            4:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [15:0] a, b;
        logic [31:0] expv, held_val;
        bit done, held, rdy;
        int cyc;
        int bad;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            a = pick();
            b = pick();
            expv = int'($signed(a)) * int'($signed(b));
            start_op(a, b);
            done = 0;
            held = 0;
            held_val = '0;
            cyc = 0;
            while (!done && cyc < 100) begin
                rdy = 1'($urandom_range(0, 1));
                bus.out_ready = rdy;
                if (bus.out_valid) begin
                    if (held) begin
                        checks++;
                        if (bus.product !== held_val) begin
                            failures++;
                            bad++;
                            $display("FAIL rand_stable n=%0d got=%h required=%h", n, bus.product, held_val);
                        end
                    end
                    if (rdy) begin
                        checks++;
                        if (bus.product !== expv) begin
                            failures++;
                            bad++;
                            $display("FAIL rand_product n=%0d a=%h b=%h got=%h required=%h",
                                     n, a, b, bus.product, expv);
                        end
                        done = 1;
                    end else begin
                        held = 1;
                        held_val = bus.product;
                    end
                end
                tick();
                cyc++;
            end
            bus.out_ready = 1'b0;
            checks++;
            if (!done || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL rand_handshake n=%0d done=%0b in_ready=%0b out_valid=%0b required 1/1/0",
                         n, done, bus.in_ready, bus.out_valid);
            end
        end
        $display("random regression 300 ops, %0d bad", bad);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
